// File: rtl/crc16_pkg.sv
// Shared CRC-16/CCITT-FALSE definitions: frame header bytes, polynomial/init constants,
// framer state encoding and the byte-step CRC function (also used by the CRC checker).
package crc16_pkg;

   localparam logic [7:0]  HDR_BYTE0 = 8'hFF;
   localparam logic [7:0]  HDR_BYTE1 = 8'hFA;
   localparam logic [15:0] CRC_POLY  = 16'h1021;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      BODY = 3'd2,
      CRC  = 3'd3,
      DONE = 3'd4
   } state_e;

   // One byte of MSB-first CRC, no reflection, no final XOR.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_step.sv
// Combinational single-byte CRC-16/CCITT-FALSE update.
module crc16_step
   import crc16_pkg::*;
(
   input  logic [15:0] iCrc,
   input  logic [7:0]  iByte,
   output logic [15:0] oCrc
);

   assign oCrc = crc16_byte(iCrc, iByte);

endmodule

// File: rtl/crc16_framer.sv
// Serialises a payload into FF FA <payload MSB-first> CRC_H CRC_L over a valid/ready byte port.
// Define CRC16_FRAMER_PARALLEL_OUT_EN to add the oPacket parallel copy of the last frame.
module crc16_framer
   import crc16_pkg::*;
#(
   parameter  int PACKAGE_SIZE = 16,
   localparam int PAYLOAD_SIZE = PACKAGE_SIZE - 4,
   localparam int STREAM_SIZE  = 8 * PACKAGE_SIZE
)
(
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iDataValid,
   input  logic [8*PAYLOAD_SIZE-1:0] iData,
   output logic [7:0]                oByte,
   output logic                      oByteValid,
   input  logic                      iByteReady,
   output logic                      oBusy,
   output logic                      oFinish,
   output logic [15:0]               oCrc,
`ifdef CRC16_FRAMER_PARALLEL_OUT_EN
   output logic [STREAM_SIZE-1:0]    oPacket,
`endif
   output logic [2:0]                oState
);

   localparam int               IDX_W    = $clog2(PACKAGE_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_SIZE - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   // Byte port handshake: oByte is offered while oByteValid=1 and is consumed only in a
   // cycle where iByteReady=1 as well; an offered byte is held unchanged until consumed.
   state_e                    state_q;
   logic [IDX_W-1:0]          idx_q;
   logic [8*PAYLOAD_SIZE-1:0] sh_q;
   logic [7:0]                byte_q;
   logic                      valid_q;
   logic                      busy_q;
   logic                      finish_q;
   logic [15:0]               crc_q;
   logic [15:0]               crc_out_q;

   logic                      xfer;
   logic [7:0]                pay_byte_d;
   logic [15:0]               crc_d;

   assign xfer       = valid_q & iByteReady;
   assign pay_byte_d = sh_q[8*PAYLOAD_SIZE-1 -: 8];

   crc16_step u_step (
      .iCrc  (crc_q),
      .iByte (byte_q),
      .oCrc  (crc_d)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         sh_q      <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         finish_q  <= 1'b0;
         crc_q     <= '0;
         crc_out_q <= '0;
      end else begin
         finish_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (iDataValid) begin
                  sh_q    <= iData;
                  crc_q   <= CRC_INIT;
                  idx_q   <= '0;
                  byte_q  <= HDR_BYTE0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= HDR;
               end
            end
            HDR: begin
               if (xfer) begin
                  if (idx_q == '0) begin
                     byte_q <= HDR_BYTE1;
                     idx_q  <= idx_q + IDX_ONE;
                  end else begin
                     byte_q  <= pay_byte_d;
                     sh_q    <= sh_q << 8;
                     idx_q   <= '0;
                     state_q <= BODY;
                  end
               end
            end
            BODY: begin
               // byte_q is the payload byte being consumed, so the CRC advances on it here.
               if (xfer) begin
                  crc_q <= crc_d;
                  if (idx_q == LAST_IDX) begin
                     crc_out_q <= crc_d;
                     byte_q    <= crc_d[15:8];
                     idx_q     <= '0;
                     state_q   <= CRC;
                  end else begin
                     byte_q <= pay_byte_d;
                     sh_q   <= sh_q << 8;
                     idx_q  <= idx_q + IDX_ONE;
                  end
               end
            end
            CRC: begin
               if (xfer) begin
                  if (idx_q == '0) begin
                     byte_q <= crc_out_q[7:0];
                     idx_q  <= idx_q + IDX_ONE;
                  end else begin
                     byte_q   <= '0;
                     valid_q  <= 1'b0;
                     finish_q <= 1'b1;
                     idx_q    <= '0;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               idx_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign oByte      = byte_q;
   assign oByteValid = valid_q;
   assign oBusy      = busy_q;
   assign oFinish    = finish_q;
   assign oCrc       = crc_out_q;
   assign oState     = state_q;

`ifdef CRC16_FRAMER_PARALLEL_OUT_EN
   logic [8*PAYLOAD_SIZE-1:0] pay_q;
   logic [STREAM_SIZE-1:0]    pkt_q;
   logic                      last_xfer;

   assign last_xfer = (state_q == CRC) && xfer && (idx_q != '0);

   // The payload copy survives the serial shift so the whole frame can be assembled at the end.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         pay_q <= '0;
         pkt_q <= '0;
      end else begin
         if ((state_q == IDLE) && iDataValid) begin
            pay_q <= iData;
         end
         if (last_xfer) begin
            pkt_q <= {HDR_BYTE0, HDR_BYTE1, pay_q, crc_out_q};
         end
      end
   end

   assign oPacket = pkt_q;
`endif

endmodule

// File: doc/crc16_framer.md
CRC16_FRAMER -- requirements
Module: crc16_framer

Interface
REQ-001 SHALL have parameter PACKAGE_SIZE, default 16: total frame bytes (2 header + payload + 2 CRC); legal range 5..64.
REQ-002 SHALL have derived constant PAYLOAD_SIZE = PACKAGE_SIZE-4 and STREAM_SIZE = 8*PACKAGE_SIZE.
REQ-003 SHALL have port iClk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port iRst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port iDataValid  in  1  one-cycle request to frame iData.
REQ-006 SHALL have port iData  in  8*PAYLOAD_SIZE  payload; MSB byte sent first.
REQ-007 SHALL have port oByte  out  8  current frame byte.
REQ-008 SHALL have port oByteValid  out  1  oByte holds a valid byte.
REQ-009 SHALL have port iByteReady  in  1  sink accepts oByte this cycle.
REQ-010 SHALL have port oBusy  out  1  frame in progress; iDataValid ignored.
REQ-011 SHALL have port oFinish  out  1  one-cycle pulse after last byte transfers.
REQ-012 SHALL have port oCrc  out  16  CRC of the most recent frame.

Function
REQ-013 SHALL emit frame 0xFF, 0xFA, payload bytes MSB-first, CRC high byte, CRC low byte.
REQ-014 SHALL compute CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR, over payload bytes only (header excluded).
REQ-015 SHALL use states IDLE, HDR, BODY, CRC, DONE; a byte transfers only in a cycle with oByteValid=1 and iByteReady=1.
REQ-016 SHALL, in IDLE with iDataValid=1, latch iData, load CRC with 0xFFFF, and enter HDR; oByteValid=1 with oByte=0xFF in the next cycle.
REQ-017 SHALL step HDR->BODY after the 2nd header byte transfers, BODY->CRC after payload byte PAYLOAD_SIZE-1 transfers, and CRC->DONE after the CRC low byte transfers.
REQ-018 SHALL update the running CRC by exactly one byte for each payload byte transferred, with no update during a stall.
REQ-019 SHALL register the final CRC into oCrc on entry to CRC state and hold it until the next frame reaches CRC.
REQ-020 SHALL hold oByte stable while oByteValid=1 and iByteReady=0 (no drop, no skip).
REQ-021 SHALL, in DONE, assert oFinish for exactly one cycle with oByteValid=0, then return to IDLE.
REQ-022 SHALL drive oBusy=1 in every state except IDLE; iDataValid in HDR/BODY/CRC/DONE is ignored and not queued.
REQ-023 SHALL sustain one byte per cycle with iByteReady held high: PACKAGE_SIZE transfer cycles, then oFinish.
REQ-024 SHALL use a byte index counter of width clog2(PACKAGE_SIZE) that never wraps within a frame.

Reset
REQ-025 SHALL, with iRst=1 at a clock edge, force IDLE, oByte=0, oByteValid=0, oBusy=0, oFinish=0, oCrc=0, and clear the index counter.
REQ-026 SHALL abort any frame when reset is asserted mid-frame; no further bytes of it SHALL appear, and reset SHALL take priority over iDataValid in the same cycle.

Configuration
REQ-027 SHALL, with macro CRC16_FRAMER_PARALLEL_OUT_EN defined, add port oPacket  out  STREAM_SIZE, holding the complete frame (header, payload, CRC), valid while oFinish=1 and held until the next frame; reset value 0.
REQ-028 SHALL, without CRC16_FRAMER_PARALLEL_OUT_EN, omit oPacket and its storage entirely, with serial behaviour identical in both builds.

Structure
REQ-029 SHALL place the header bytes 0xFF/0xFA, the CRC poly/init constants, the state enum and the byte-step CRC function in shared package crc16_pkg, which the existing CRC checker also uses.
REQ-030 SHALL instantiate one combinational sub-module crc16_step (16-bit crc in, 8-bit byte in, 16-bit crc out).

Verification
REQ-031 SHALL check reset: iRst=1 for 2 cycles -> all outputs 0, oBusy=0.
REQ-032 SHALL check the golden frame: PACKAGE_SIZE=13, payload "123456789" (0x31..0x39), iByteReady=1 -> FF FA 31 32 33 34 35 36 37 38 39 29 B1 in 13 consecutive cycles; oCrc=0x29B1; oFinish the cycle after.
REQ-033 SHALL check backpressure: same frame, iByteReady toggling 1,0 -> identical byte sequence, oByte stable in every stalled cycle, final oCrc=0x29B1.
REQ-034 SHALL check a busy request: second iDataValid with different payload during BODY -> only the first frame emitted; a new request after return to IDLE is framed normally.
REQ-035 SHALL check mid-frame reset: iRst pulse after 5th byte -> oByteValid=0 next cycle; next request yields a frame starting 0xFF 0xFA.
REQ-036 SHALL check the parallel build: with CRC16_FRAMER_PARALLEL_OUT_EN, the golden frame -> oPacket=104'hFFFA31323334353637383929B1 while oFinish=1.
